// File: rtl/puf_bist_pkg.sv
// Shared definitions for the PUF BIST challenge/response collector:
// parameter defaults and the collector FSM state encoding.
package puf_bist_pkg;

  localparam int DEF_N_CB    = 64;
  localparam int DEF_N_RNG   = 4;
  localparam int DEF_N_EVAL  = 5;
  localparam int DEF_SETTLE  = 4;
  localparam int DEF_TIMEOUT = 32;

  typedef enum logic [2:0] {
    ST_REFRESH,
    ST_LATCH,
    ST_SETTLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_OUTPUT
  } state_t;

endpackage

// File: rtl/crp_vote_acc.sv
// Accumulates PUF evaluation bits for one challenge and derives the
// majority-vote response and the stability flag.
module crp_vote_acc
  import puf_bist_pkg::*;
#(
  parameter int N_EVAL = DEF_N_EVAL,
  localparam int CW = $clog2(N_EVAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          sample_en,
  input  logic          sample_bit,
  input  logic          timed_out,
  output logic [CW-1:0] ones,
  output logic          last,
  output logic          response,
  output logic          stable
);

  localparam logic [CW-1:0] MAX_EVAL  = CW'(N_EVAL);
  localparam logic [CW-1:0] LAST_EVAL = CW'(N_EVAL - 1);
  localparam logic [CW-1:0] HALF      = CW'(N_EVAL / 2);

  logic [CW-1:0] evals;

  // Saturate at N_EVAL so a stray enable can never wrap the counters.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      evals <= '0;
      ones  <= '0;
    end else if (sample_en && evals != MAX_EVAL) begin
      evals <= evals + CW'(1);
      ones  <= ones + CW'(sample_bit);
    end
  end

  assign last     = (evals == LAST_EVAL);
  assign response = (ones > HALF);
  assign stable   = ((ones == '0) || (ones == MAX_EVAL)) && !timed_out;

endmodule

// File: rtl/crp_collector.sv
// Collects one CRP record: refreshes the challenge, latches it onto the PUF,
// runs N_EVAL settle/launch/wait evaluations and presents a voted record.
module crp_collector
  import puf_bist_pkg::*;
#(
  parameter int N_CB    = DEF_N_CB,
  parameter int N_RNG   = DEF_N_RNG,
  parameter int N_EVAL  = DEF_N_EVAL,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int OW = $clog2(N_EVAL + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CB-1:0] c_in,
  output logic [N_CB-1:0] puf_c,
  output logic            puf_start,
  input  logic            puf_done,
  input  logic            puf_r,
  output logic            crp_valid,
  input  logic            crp_ready,
  output logic [N_CB-1:0] crp_challenge,
  output logic            crp_response,
  output logic [OW-1:0]   crp_ones,
  output logic            crp_stable,
  output logic            crp_timeout
);

  localparam int REF_CYC = N_CB / N_RNG;
  localparam int RW = $clog2(REF_CYC + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [RW-1:0] REF_LAST = RW'(REF_CYC - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t        state;
  logic [RW-1:0] ref_cnt;
  logic [SW-1:0] set_cnt;
  logic [TW-1:0] to_cnt;
  logic          to_flag;

  logic          eval_end;
  logic          vote_last;
  logic          vote_resp;
  logic          vote_stable;
  logic [OW-1:0] vote_ones;

  // An evaluation ends on puf_done or on the last allowed WAIT cycle;
  // puf_done on that same cycle still supplies a real sample.
  assign eval_end = (state == ST_WAIT) && (puf_done || (to_cnt == TO_LAST));

  crp_vote_acc #(.N_EVAL(N_EVAL)) u_vote (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == ST_LATCH),
    .sample_en  (eval_end),
    .sample_bit (puf_done & puf_r),
    .timed_out  (to_flag),
    .ones       (vote_ones),
    .last       (vote_last),
    .response   (vote_resp),
    .stable     (vote_stable)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_REFRESH;
      ref_cnt   <= '0;
      set_cnt   <= '0;
      to_cnt    <= '0;
      to_flag   <= 1'b0;
      puf_c     <= '0;
      puf_start <= 1'b0;
      crp_valid <= 1'b0;
    end else begin
      puf_start <= 1'b0;
      case (state)
        ST_REFRESH: begin
          if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            state   <= ST_LATCH;
          end else begin
            ref_cnt <= ref_cnt + RW'(1);
          end
        end
        ST_LATCH: begin
          puf_c   <= c_in;
          to_flag <= 1'b0;
          set_cnt <= '0;
          state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (set_cnt == SET_LAST) begin
            set_cnt   <= '0;
            puf_start <= 1'b1;
            state     <= ST_LAUNCH;
          end else begin
            set_cnt <= set_cnt + SW'(1);
          end
        end
        ST_LAUNCH: begin
          to_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eval_end) begin
            if (!puf_done) to_flag <= 1'b1;
            set_cnt <= '0;
            if (vote_last) begin
              crp_valid <= 1'b1;
              state     <= ST_OUTPUT;
            end else begin
              state <= ST_SETTLE;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ST_OUTPUT: begin
          if (crp_ready) begin
            crp_valid <= 1'b0;
            ref_cnt   <= '0;
            state     <= ST_REFRESH;
          end
        end
        default: state <= ST_REFRESH;
      endcase
    end
  end

  // Record fields come from registers frozen during OUTPUT; they read as
  // zero whenever no record is on offer.
  assign crp_challenge = crp_valid ? puf_c : '0;
  assign crp_ones      = crp_valid ? vote_ones : '0;
  assign crp_response  = crp_valid & vote_resp;
  assign crp_stable    = crp_valid & vote_stable;
  assign crp_timeout   = crp_valid & to_flag;

endmodule

// File: tb/tb_crp_collector.sv
// Directed bench for crp_collector: a driver plays PUF evaluation sequences and
// queues the hand-computed record; a negedge monitor checks every offered record.
module tb_crp_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] c_in = '0;
  logic [63:0] puf_c;
  logic        puf_start;
  logic        puf_done = 1'b0;
  logic        puf_r = 1'b1;
  logic        crp_valid;
  logic        crp_ready = 1'b1;
  logic [63:0] crp_challenge;
  logic        crp_response;
  logic [2:0]  crp_ones;
  logic        crp_stable;
  logic        crp_timeout;

  crp_collector dut (
    .clk           (clk),
    .rst           (rst),
    .c_in          (c_in),
    .puf_c         (puf_c),
    .puf_start     (puf_start),
    .puf_done      (puf_done),
    .puf_r         (puf_r),
    .crp_valid     (crp_valid),
    .crp_ready     (crp_ready),
    .crp_challenge (crp_challenge),
    .crp_response  (crp_response),
    .crp_ones      (crp_ones),
    .crp_stable    (crp_stable),
    .crp_timeout   (crp_timeout)
  );

  // ---------------- clock / reset / challenge stream ----------------
  always #5 clk = ~clk;

  int gcyc = 0;
  int last_xfer = 0;
  int n_pass = 0;
  int n_total = 0;
  logic [69:0] exp_q[$];

  function automatic logic [63:0] mk(input int g);
    logic [31:0] gv;
    gv = 32'(g);
    return {gv * 32'h9E37_79B9, ~gv ^ 32'h5A5A_1234};
  endfunction

  // During the cycle after the g-th rising edge, c_in carries mk(g).
  always @(posedge clk) begin
    gcyc++;
    #1 c_in = mk(gcyc);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_rst_outputs(input string nm);
    check({nm, "_puf_c"}, puf_c, 64'd0);
    check({nm, "_challenge"}, crp_challenge, 64'd0);
    check({nm, "_flags"},
          64'({puf_start, crp_valid, crp_response, crp_ones, crp_stable, crp_timeout}), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit xfer_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      xfer_prev = 1'b0;
    end else begin
      if (xfer_prev) check("valid_after_xfer", 64'(crp_valid), 64'd0);
      xfer_prev = 1'b0;
      if (crp_valid) begin
        check("record_expected", 64'(exp_q.size() != 0), 64'd1);
        check("no_start_in_output", 64'(puf_start), 64'd0);
        if (exp_q.size() != 0) begin
          logic [69:0] e;
          e = exp_q[0];
          check("rec_challenge", crp_challenge, e[69:6]);
          check("rec_ones", 64'(crp_ones), 64'(e[5:3]));
          check("rec_response", 64'(crp_response), 64'(e[2]));
          check("rec_stable", 64'(crp_stable), 64'(e[1]));
          check("rec_timeout", 64'(crp_timeout), 64'(e[0]));
          if (crp_ready) begin
            void'(exp_q.pop_front());
            xfer_prev = 1'b1;
            last_xfer = gcyc;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_start(output int g, output bit ok);
    ok = 1'b0;
    g  = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (puf_start) begin
        ok = 1'b1;
        g  = gcyc;
        break;
      end
    end
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (crp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("valid_seen", 64'(seen), 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // r[i] is the bit returned by evaluation i after dly extra WAIT cycles;
  // evaluations flagged in to_mask never see puf_done. abort_at >= 0 pulses
  // rst during WAIT of that evaluation instead of answering it.
  task automatic run_record(input logic [4:0] r, input int dly, input logic [4:0] to_mask,
                            input bit stray, input int abort_at, input int exp_g0,
                            input logic [2:0] e_ones, input logic e_resp,
                            input logic e_stab, input logic e_tmo);
    int g, gprev, wl;
    bit ok;
    gprev = 0;
    wl = 0;
    for (int i = 0; i < 5; i++) begin
      wait_start(g, ok);
      check("start_seen", 64'(ok), 64'd1);
      if (!ok) return;
      if (i == 0) begin
        check("first_start_cycle", 64'(g), 64'(exp_g0));
        if (abort_at < 0) exp_q.push_back({mk(g - 5), e_ones, e_resp, e_stab, e_tmo});
      end else begin
        check("start_gap", 64'(g - gprev), 64'(1 + wl + 4));
      end
      gprev = g;
      @(posedge clk); #1;
      if (i == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_rst_outputs("abort_wait");
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (to_mask[i]) begin
        wl = 32;
      end else begin
        repeat (dly) begin
          @(posedge clk); #1;
        end
        puf_done = 1'b1;
        puf_r    = r[i];
        @(posedge clk); #1;
        puf_done = 1'b0;
        puf_r    = 1'b1;
        if (stray) begin
          puf_done = 1'b1;
          @(posedge clk); #1;
          puf_done = 1'b0;
        end
        wl = dly + 1;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  grel;
    bit  early;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst_outputs("reset");
    @(posedge clk); #1;
    rst  = 1'b0;
    grel = gcyc;

    early = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (puf_start) early = 1'b1;
      if (k == 16) check("puf_c_before_latch", puf_c, 64'd0);
      if (k == 17) check("latched_challenge", puf_c, mk(grel + 16));
    end
    check("no_early_start", 64'(early), 64'd0);

    // r = 1,1,0,1,0 with prompt puf_done
    run_record(5'b01011, 0, 5'b00000, 1'b0, -1, grel + 21, 3'd3, 1'b1, 1'b0, 1'b0);
    drain();
    // all ones, puf_done two cycles into WAIT
    run_record(5'b11111, 2, 5'b00000, 1'b0, -1, last_xfer + 22, 3'd5, 1'b1, 1'b1, 1'b0);
    drain();
    // all zeros, plus stray puf_done/puf_r=1 outside WAIT
    run_record(5'b00000, 0, 5'b00000, 1'b1, -1, last_xfer + 22, 3'd0, 1'b0, 1'b1, 1'b0);
    drain();
    // puf_done never arrives
    run_record(5'b11111, 0, 5'b11111, 1'b0, -1, last_xfer + 22, 3'd0, 1'b0, 1'b0, 1'b1);
    drain();
    // puf_done on the 32nd WAIT cycle still counts
    run_record(5'b11111, 31, 5'b00000, 1'b0, -1, last_xfer + 22, 3'd5, 1'b1, 1'b1, 1'b0);
    drain();
    // one timeout among four ones
    run_record(5'b11111, 1, 5'b00100, 1'b0, -1, last_xfer + 22, 3'd4, 1'b1, 1'b0, 1'b1);
    drain();

    // consumer stalls 10 cycles in OUTPUT
    crp_ready = 1'b0;
    run_record(5'b00101, 0, 5'b00000, 1'b0, -1, last_xfer + 22, 3'd2, 1'b0, 1'b0, 1'b0);
    wait_valid();
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    crp_ready = 1'b1;
    drain();

    // reset during WAIT of the third evaluation
    run_record(5'b11111, 0, 5'b00000, 1'b0, 2, last_xfer + 22, 3'd0, 1'b0, 1'b0, 1'b0);
    grel = gcyc;
    run_record(5'b11111, 0, 5'b00000, 1'b0, -1, grel + 21, 3'd5, 1'b1, 1'b1, 1'b0);
    drain();

    // reset while a record waits in OUTPUT
    crp_ready = 1'b0;
    run_record(5'b00000, 0, 5'b00000, 1'b0, -1, last_xfer + 22, 3'd0, 1'b0, 1'b1, 1'b0);
    wait_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_rst_outputs("abort_output");
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    crp_ready = 1'b1;
    grel = gcyc;
    run_record(5'b10011, 0, 5'b00000, 1'b0, -1, grel + 21, 3'd3, 1'b1, 1'b0, 1'b0);
    drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/crp_collector.md
CRP_COLLECTOR -- requirements
Module: crp_collector

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- N_CB, 64, challenge width in bits.
- N_RNG, 4, fresh random bits the challenge source shifts in per clock.
- N_EVAL, 5, PUF evaluations per challenge; must be odd.
- SETTLE, 4, idle cycles between challenge change/previous evaluation and launch.
- TIMEOUT, 32, max cycles waiting for puf_done.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, synchronous, active-high reset.
- c_in, in, N_CB, shifting challenge stream from the challenge generator.
- puf_c, out, N_CB, challenge held on PUF inputs.
- puf_start, out, 1, one-cycle PUF launch pulse.
- puf_done, in, 1, PUF response-valid pulse.
- puf_r, in, 1, PUF response bit, sampled only with puf_done.
- crp_valid, out, 1, CRP record available.
- crp_ready, in, 1, consumer accepts record.
- crp_challenge, out, N_CB, challenge of the record.
- crp_response, out, 1, majority-vote response.
- crp_ones, out, $clog2(N_EVAL+1), count of 1 responses.
- crp_stable, out, 1, all N_EVAL evaluations agreed.
- crp_timeout, out, 1, at least one evaluation timed out.

Function
REQ-003 FSM states SHALL be REFRESH, LATCH, SETTLE, LAUNCH, WAIT, OUTPUT.
REQ-004 REFRESH SHALL last exactly N_CB/N_RNG cycles (16 at defaults) so c_in is fully renewed, then go to LATCH.
REQ-005 LATCH SHALL register puf_c <= c_in for one cycle, clear the evaluation counter, ones count and timeout flag, then go to SETTLE.
REQ-006 SETTLE SHALL last SETTLE cycles, then go to LAUNCH; puf_c SHALL be constant from LATCH until the next LATCH.
REQ-007 LAUNCH SHALL assert puf_start for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-008 In WAIT, puf_done=1 SHALL sample puf_r, add it to the ones count, and increment the evaluation counter.
REQ-009 In WAIT, if TIMEOUT cycles elapse without puf_done, the evaluation SHALL count as 0, set the timeout flag, and increment the evaluation counter.
REQ-010 When puf_done and timeout expiry coincide, puf_done SHALL win.
REQ-011 puf_done outside WAIT SHALL be ignored.
REQ-012 After an evaluation, if the evaluation count < N_EVAL the FSM SHALL go to SETTLE; otherwise it SHALL go to OUTPUT.
REQ-013 On entering OUTPUT, crp_valid SHALL assert, with:
- crp_challenge = puf_c.
- crp_ones = ones count.
- crp_response = (ones > N_EVAL/2).
- crp_stable = (ones == 0 or ones == N_EVAL) and no timeout.
- crp_timeout = timeout flag.
REQ-014 Record outputs SHALL stay stable while crp_valid=1 and crp_ready=0; no puf_start SHALL occur in OUTPUT.
REQ-015 A transfer SHALL occur on the cycle crp_valid and crp_ready are both 1; the next cycle SHALL be REFRESH with crp_valid=0.
REQ-016 crp_ready SHALL be ignored while crp_valid=0.
REQ-017 Counters SHALL be sized to their maxima (N_EVAL, TIMEOUT, SETTLE, N_CB/N_RNG) and SHALL never wrap.

Reset
REQ-018 While rst=1, on the clock edge:
- State SHALL be REFRESH.
- All counters SHALL be 0.
- puf_c, puf_start, crp_valid, crp_response, crp_ones, crp_stable and crp_timeout SHALL be 0; crp_challenge SHALL be 0.
REQ-019 Reset asserted mid-operation, in any state including OUTPUT, SHALL abort and discard the record; the sequence SHALL restart from REFRESH after release.

Structure
REQ-020 The FSM state encodings and parameter defaults SHALL live in shared package puf_bist_pkg.
REQ-021 The ones count, evaluation count and majority/stability logic SHALL form one sub-module, crp_vote_acc, with clear, sample-enable and bit inputs.

Verification (defaults; cycle 0 = first cycle after rst release)
REQ-022 Reset release: REFRESH spans cycles 0-15, LATCH at 16, first puf_start at cycle 21, and puf_c equals c_in as sampled at cycle 16.
REQ-023 puf_r = 1,1,0,1,0 with prompt puf_done: crp_ones=3, crp_response=1, crp_stable=0, crp_timeout=0.
REQ-024 puf_r = all 1: crp_ones=5, crp_response=1, crp_stable=1; all 0 gives crp_ones=0, crp_response=0, crp_stable=1.
REQ-025 puf_done never asserted: each WAIT lasts 32 cycles, crp_timeout=1, crp_ones=0, crp_stable=0; puf_done coinciding with cycle 32 counts as a valid sample.
REQ-026 crp_ready held low 10 cycles in OUTPUT: crp_valid and all record fields unchanged, no puf_start; REFRESH starts the cycle after the handshake.
REQ-027 rst pulsed during WAIT of the 3rd evaluation: all outputs 0, and after release the next puf_start occurs at cycle 21.
